// File: rtl/booth_mult_r8_pipe.sv
// booth_mult_r8_pipe: radix-8 Booth sequential multiply / multiply-accumulate with valid/ready handshakes
module booth_mult_r8_pipe #(
  parameter int WIDTH = 8,
  localparam int ITER = (WIDTH + 3) / 3,
  localparam int PW = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_sign,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PW-1:0]    out_data,
  output logic             busy
);
  localparam int HW = WIDTH + 3;
  localparam int LW = 3 * ITER;
  localparam int CW = $clog2(ITER) + 1;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state, state_n;
  logic [HW-1:0] a_r, a3_r, hi, a_x, mag, sum;
  logic [LW:0] lo;
  logic [LW-1:0] b_x;
  logic [HW+LW:0] nxt;
  logic [CW-1:0] cnt;
  logic [PW-1:0] res;
  logic [3:0] code;
  logic [2:0] m;
  logic acc_r, neg, last, accept;
  assign busy = state == RUN;
  assign out_valid = state == HOLD;
  assign in_ready = !busy && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign out_data = res;
  assign last = cnt == CW'(ITER - 1);
  assign a_x = {{3{in_sign[1] & in_a[WIDTH-1]}}, in_a};
  assign b_x = {{(LW - WIDTH){in_sign[0] & in_b[WIDTH-1]}}, in_b};
  // Negative digits reuse the positive magnitude table on the inverted low bits.
  always_comb begin
    code = lo[3:0];
    m = code[3] ? ~code[2:0] : code[2:0];
    neg = code[3] & ~&code[2:0];
    mag = m == 3'd0 ? '0 : m == 3'd7 ? a_r << 2 : m >= 3'd5 ? a3_r : m >= 3'd3 ? a_r << 1 : a_r;
    sum = hi + (neg ? ~mag : mag) + HW'(neg);
    nxt = $signed({sum, lo}) >>> 3;
  end
  always_comb begin
    state_n = state;
    if (accept) state_n = RUN;
    else if (state == RUN && last) state_n = HOLD;
    else if (state == HOLD && out_ready) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_r <= '0;
      a3_r <= '0;
      acc_r <= 1'b0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      res <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_r <= a_x;
        a3_r <= a_x + (a_x << 1);
        acc_r <= in_acc;
        hi <= '0;
        lo <= {b_x, 1'b0};
        cnt <= '0;
      end else if (state == RUN) begin
        {hi, lo} <= nxt;
        cnt <= cnt + 1'b1;
        if (last) res <= acc_r ? res + nxt[PW:1] : nxt[PW:1];
      end
    end
  end
endmodule
